// File: rtl/rle_uart_pkg.sv
// Shared definitions for the row RLE UART link: packet layout, channel codes
// and ID sequencing, used by both the compressor and this decoder.
package rle_uart_pkg;

  localparam int PacketLength   = 6;
  localparam int IdModulus      = 255;
  localparam int RunLengthWidth = 12;

  localparam int IdByte     = 0;
  localparam int YByte      = 1;
  localparam int XByte      = 2;
  localparam int MiscByte   = 3;
  localparam int ValueByte  = 4;
  localparam int AmountByte = 5;

  localparam int MiscXBit     = 0;
  localparam int MiscYBit     = 1;
  localparam int MiscChanLsb  = 2;
  localparam int MiscCountLsb = 4;

  localparam logic [1:0] CHAN_Y       = 2'b00;
  localparam logic [1:0] CHAN_U       = 2'b01;
  localparam logic [1:0] CHAN_V       = 2'b10;
  localparam logic [1:0] CHAN_INVALID = 2'b11;

  typedef enum logic [1:0] {
    EXP_IDLE = 2'd0,
    EXP_LOAD = 2'd1,
    EXP_EMIT = 2'd2
  } exp_state_e;

  typedef struct packed {
    logic [1:0]                chan;
    logic [8:0]                y;
    logic [8:0]                x;
    logic [RunLengthWidth-1:0] count;
    logic [7:0]                val;
  } rle_run_t;

  typedef struct packed {
    logic [7:0] id;
    rle_run_t   run;
  } rle_pkt_t;

  // raw holds byte 0 in bits [7:0], byte 5 in bits [47:40].
  function automatic rle_pkt_t decode_packet(input logic [8*PacketLength-1:0] raw);
    rle_pkt_t   p;
    logic [7:0] misc;
    misc        = raw[8*MiscByte +: 8];
    p.id        = raw[8*IdByte +: 8];
    p.run.y     = {raw[8*YByte +: 8], misc[MiscYBit]};
    p.run.x     = {raw[8*XByte +: 8], misc[MiscXBit]};
    p.run.chan  = misc[MiscChanLsb +: 2];
    p.run.count = {misc[MiscCountLsb +: 4], raw[8*AmountByte +: 8]};
    p.run.val   = raw[8*ValueByte +: 8];
    return p;
  endfunction

  // IDs count 0..IdModulus-1 and wrap to 0.
  function automatic logic [7:0] next_id(input logic [7:0] id);
    if (id >= 8'(IdModulus - 1)) begin
      return id - 8'(IdModulus - 1);
    end
    return id + 8'd1;
  endfunction

endpackage

// File: rtl/rle_packet_assembler.sv
// Collects RX bytes into a 6-byte packet register, strobes on completion and
// discards a partial packet when the byte stream goes quiet for too long.
module rle_packet_assembler
  import rle_uart_pkg::*;
#(
  parameter int TimeoutCycles = 4096
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                i_byte,
  input  logic                      i_byte_valid,
  output logic [8*PacketLength-1:0] o_raw,
  output logic                      o_complete,
  output logic                      o_timeout
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [2:0]                idx_q, idx_d;
  logic [CntW-1:0]           idle_q, idle_d;
  logic [8*PacketLength-1:0] raw_q, raw_d;
  logic                      complete_q, complete_d;
  logic                      timeout_q, timeout_d;

  always_comb begin
    idx_d      = idx_q;
    idle_d     = idle_q;
    raw_d      = raw_q;
    complete_d = 1'b0;
    timeout_d  = 1'b0;
    if (i_byte_valid) begin
      raw_d[8*idx_q +: 8] = i_byte;
      idle_d              = '0;
      if (idx_q == 3'(PacketLength - 1)) begin
        idx_d      = '0;
        complete_d = 1'b1;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end else if (idx_q != '0) begin
      // Only a partially received packet can time out.
      if (idle_q == CntW'(TimeoutCycles - 1)) begin
        idx_d     = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + CntW'(1);
      end
    end else begin
      idle_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      idx_q      <= '0;
      idle_q     <= '0;
      raw_q      <= '0;
      complete_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      idle_q     <= idle_d;
      raw_q      <= raw_d;
      complete_q <= complete_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_raw      = raw_q;
  assign o_complete = complete_q;
  assign o_timeout  = timeout_q;

endmodule

// File: rtl/rle_packet_decoder.sv
// Receive-side RLE decoder: validates assembled packets, tracks packet IDs and
// expands each run into per-sample writes toward the YUV422 frame store.
module rle_packet_decoder
  import rle_uart_pkg::*;
#(
  parameter int RowPixelWidth = 640,
  parameter int MaxRunLength  = RunLengthWidth,
  parameter int TimeoutCycles = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] i_byte,
  input  logic       i_byte_valid,
  input  logic       i_wr_ready,
  output logic       o_wr_en,
  output logic [1:0] o_wr_chan,
  output logic [8:0] o_wr_y,
  output logic [8:0] o_wr_x,
  output logic [7:0] o_wr_val,
  output logic       o_busy,
  output logic       o_id_gap,
  output logic       o_bad_chan,
  output logic       o_overflow,
  output logic       o_timeout
);

  // Run x is kept wide so clipped samples past the row end never wrap back
  // into the visible range.
  localparam int XW = MaxRunLength + 2;

  function automatic logic [XW-1:0] chan_width(input logic [1:0] chan);
    return (chan == CHAN_Y) ? XW'(RowPixelWidth) : XW'(RowPixelWidth / 2);
  endfunction

  logic [8*PacketLength-1:0] asm_raw;
  logic                      asm_complete;
  logic                      asm_timeout;

  rle_packet_assembler #(
    .TimeoutCycles(TimeoutCycles)
  ) u_assembler (
    .CLK         (CLK),
    .RST         (RST),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_raw       (asm_raw),
    .o_complete  (asm_complete),
    .o_timeout   (asm_timeout)
  );

  rle_pkt_t pkt_in;
  logic     bad_chan, slot_free, accept, overflow, id_gap;

  logic                    pend_full_q, pend_full_d;
  rle_run_t                pend_run_q, pend_run_d;
  logic                    id_armed_q, id_armed_d;
  logic [7:0]              id_exp_q, id_exp_d;
  exp_state_e              state_q, state_d;
  logic [1:0]              run_chan_q, run_chan_d;
  logic [8:0]              run_y_q, run_y_d;
  logic [XW-1:0]           run_x_q, run_x_d;
  logic [7:0]              run_val_q, run_val_d;
  logic [MaxRunLength-1:0] run_rem_q, run_rem_d;
  logic                    in_range, wr_en;

  // Intake: a LOAD in progress frees the slot this cycle, so a packet
  // completing at the same time is accepted rather than overflowing.
  always_comb begin
    pkt_in      = decode_packet(asm_raw);
    bad_chan    = asm_complete && (pkt_in.run.chan == CHAN_INVALID);
    slot_free   = !pend_full_q || (state_q == EXP_LOAD);
    accept      = asm_complete && !bad_chan && slot_free;
    overflow    = asm_complete && !bad_chan && !slot_free;
    pend_full_d = pend_full_q;
    pend_run_d  = pend_run_q;
    id_armed_d  = id_armed_q;
    id_exp_d    = id_exp_q;
    id_gap      = 1'b0;
    if (state_q == EXP_LOAD) begin
      pend_full_d = 1'b0;
    end
    if (accept) begin
      pend_full_d = 1'b1;
      pend_run_d  = pkt_in.run;
      id_gap      = id_armed_q && (pkt_in.id != id_exp_q);
      id_armed_d  = 1'b1;
      id_exp_d    = next_id(pkt_in.id);
    end
  end

  // Write port handshake: o_wr_en with the chan/y/x/val fields is a request
  // held stable until the cycle i_wr_ready is also high; that cycle is the
  // transfer, and at most one transfer happens per cycle.
  always_comb begin
    in_range   = run_x_q < chan_width(run_chan_q);
    wr_en      = (state_q == EXP_EMIT) && in_range;
    state_d    = state_q;
    run_chan_d = run_chan_q;
    run_y_d    = run_y_q;
    run_x_d    = run_x_q;
    run_val_d  = run_val_q;
    run_rem_d  = run_rem_q;
    case (state_q)
      EXP_IDLE: begin
        // Entering LOAD alongside the slot write saves a cycle of latency.
        if (pend_full_q || accept) begin
          state_d = EXP_LOAD;
        end
      end
      EXP_LOAD: begin
        run_chan_d = pend_run_q.chan;
        run_y_d    = pend_run_q.y;
        run_x_d    = XW'(pend_run_q.x);
        run_val_d  = pend_run_q.val;
        run_rem_d  = MaxRunLength'(pend_run_q.count);
        state_d    = (pend_run_q.count == '0) ? EXP_IDLE : EXP_EMIT;
      end
      EXP_EMIT: begin
        // Clipped samples advance without a write.
        if (!in_range || i_wr_ready) begin
          run_x_d   = run_x_q + XW'(1);
          run_rem_d = run_rem_q - MaxRunLength'(1);
          if (run_rem_q == MaxRunLength'(1)) begin
            state_d = EXP_IDLE;
          end
        end
      end
      default: state_d = EXP_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      pend_full_q <= 1'b0;
      pend_run_q  <= '0;
      id_armed_q  <= 1'b0;
      id_exp_q    <= '0;
      state_q     <= EXP_IDLE;
      run_chan_q  <= '0;
      run_y_q     <= '0;
      run_x_q     <= '0;
      run_val_q   <= '0;
      run_rem_q   <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_run_q  <= pend_run_d;
      id_armed_q  <= id_armed_d;
      id_exp_q    <= id_exp_d;
      state_q     <= state_d;
      run_chan_q  <= run_chan_d;
      run_y_q     <= run_y_d;
      run_x_q     <= run_x_d;
      run_val_q   <= run_val_d;
      run_rem_q   <= run_rem_d;
    end
  end

  assign o_wr_en    = wr_en;
  assign o_wr_chan  = run_chan_q;
  assign o_wr_y     = run_y_q;
  assign o_wr_x     = run_x_q[8:0];
  assign o_wr_val   = run_val_q;
  assign o_busy     = pend_full_q || (state_q != EXP_IDLE);
  assign o_id_gap   = id_gap;
  assign o_bad_chan = bad_chan;
  assign o_overflow = overflow;
  assign o_timeout  = asm_timeout;

endmodule

// File: tb/tb_rle_packet_decoder.sv
// Bench for rle_packet_decoder: directed scenarios plus randomized packets,
// all writes and status pulses compared against a packet-level model.
module tb_rle_packet_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] i_byte = 8'd0;
  logic       i_byte_valid = 1'b0;
  logic       i_wr_ready = 1'b1;
  logic       o_wr_en;
  logic [1:0] o_wr_chan;
  logic [8:0] o_wr_y;
  logic [8:0] o_wr_x;
  logic [7:0] o_wr_val;
  logic       o_busy, o_id_gap, o_bad_chan, o_overflow, o_timeout;

  rle_packet_decoder dut (
    .CLK         (CLK),
    .RST         (RST),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .i_wr_ready  (i_wr_ready),
    .o_wr_en     (o_wr_en),
    .o_wr_chan   (o_wr_chan),
    .o_wr_y      (o_wr_y),
    .o_wr_x      (o_wr_x),
    .o_wr_val    (o_wr_val),
    .o_busy      (o_busy),
    .o_id_gap    (o_id_gap),
    .o_bad_chan  (o_bad_chan),
    .o_overflow  (o_overflow),
    .o_timeout   (o_timeout)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // expected writes {chan, y, x, val}
  logic [27:0] exp_q[$];
  logic [27:0] mon_got, mon_want;

  int exp_gap = 0, exp_bad = 0, exp_ovf = 0, exp_to = 0;
  int gap_cnt = 0, bad_cnt = 0, ovf_cnt = 0, to_cnt = 0;
  bit m_armed = 1'b0;
  int m_exp_id = 0;
  int ready_mode = 1;  // 0 = low, 1 = high, 2 = random

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // reference model: packet rules applied directly
  task automatic model_packet(input int id, input int chan, input int y, input int x,
                              input int cnt, input int val, input bit drop);
    int width;
    if (chan == 3) begin
      exp_bad++;
    end else if (drop) begin
      exp_ovf++;
    end else begin
      if (m_armed && id != m_exp_id) exp_gap++;
      m_armed  = 1'b1;
      m_exp_id = (id + 1) % 255;
      width = (chan == 0) ? 640 : 320;
      for (int i = 0; i < cnt; i++) begin
        if (x + i < width) exp_q.push_back({2'(chan), 9'(y), 9'(x + i), 8'(val)});
      end
    end
  endtask

  // driver tasks
  always @(posedge CLK) begin
    #1;
    case (ready_mode)
      0:       i_wr_ready = 1'b0;
      1:       i_wr_ready = 1'b1;
      default: i_wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    i_byte       = b;
    i_byte_valid = 1'b1;
    @(negedge CLK);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_packet(input int id, input int chan, input int y, input int x,
                             input int cnt, input int val, input bit drop);
    logic [7:0] b[6];
    logic [8:0] yy, xx;
    logic [11:0] cc;
    yy = 9'(y);
    xx = 9'(x);
    cc = 12'(cnt);
    model_packet(id, chan, y, x, cnt, val, drop);
    b[0] = 8'(id);
    b[1] = yy[8:1];
    b[2] = xx[8:1];
    b[3] = {cc[11:8], 2'(chan), yy[0], xx[0]};
    b[4] = 8'(val);
    b[5] = cc[7:0];
    for (int i = 0; i < 6; i++) send_byte(b[i]);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while ((o_busy || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check("drain_busy", {31'd0, o_busy}, 32'd0);
    check("drain_pending_writes", exp_q.size(), 32'd0);
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_gap"}, gap_cnt, exp_gap);
    check({tag, "_bad"}, bad_cnt, exp_bad);
    check({tag, "_ovf"}, ovf_cnt, exp_ovf);
    check({tag, "_timeout"}, to_cnt, exp_to);
  endtask

  task automatic reset_dut();
    @(posedge CLK);
    #2 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_wr", {o_wr_en, o_wr_chan, o_wr_y, o_wr_x}, 32'd0);
    check("reset_status", {o_wr_val, o_busy, o_id_gap, o_bad_chan, o_overflow, o_timeout}, 32'd0);
    RST = 1'b1;
    exp_q.delete();
    m_armed = 1'b0;
  endtask

  // scoreboard: writes transfer where o_wr_en && i_wr_ready
  always @(negedge CLK) begin
    if (RST) begin
      if (o_id_gap) gap_cnt++;
      if (o_bad_chan) bad_cnt++;
      if (o_overflow) ovf_cnt++;
      if (o_timeout) to_cnt++;
      if (o_wr_en && i_wr_ready) begin
        mon_got = {o_wr_chan, o_wr_y, o_wr_x, o_wr_val};
        if (exp_q.size() != 0) mon_want = exp_q.pop_front();
        else mon_want = '1;
        check("write", 32'(mon_got), 32'(mon_want));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int id, chan, cnt;
    reset_dut();

    // single Y run, latency and 1 write/cycle
    ready_mode = 1;
    send_packet(0, 0, 10, 20, 3, 8'h80, 1'b0);
    @(negedge CLK); check("latency_edge1", {31'd0, o_wr_en}, 32'd0);
    @(negedge CLK); check("latency_edge2", {31'd0, o_wr_en}, 32'd1);
    @(negedge CLK); check("run_w2", {31'd0, o_wr_en}, 32'd1);
    @(negedge CLK); check("run_w3", {31'd0, o_wr_en}, 32'd1);
    @(negedge CLK); check("run_end", {31'd0, o_wr_en}, 32'd0);
    wait_drain(50);

    // stalled long run, second pending, third overflows
    ready_mode = 0;
    send_packet(1, 0, 5, 0, 200, 8'h11, 1'b0);
    send_packet(2, 1, 6, 7, 5, 8'h22, 1'b0);
    send_packet(3, 2, 7, 9, 4, 8'h33, 1'b1);
    @(negedge CLK);
    check("overflow_busy", {31'd0, o_busy}, 32'd1);
    check_pulses("overflow");
    ready_mode = 2;
    wait_drain(2000);

    // invalid channel dropped, ID tracker untouched
    ready_mode = 1;
    send_packet(3, 3, 1, 1, 5, 8'h44, 1'b0);
    @(negedge CLK);
    check_pulses("badchan");
    send_packet(3, 0, 2, 30, 2, 8'h55, 1'b0);
    wait_drain(50);
    check_pulses("after_badchan");

    // partial packet times out
    send_byte(8'd4); send_byte(8'd1); send_byte(8'd2); send_byte(8'd3); send_byte(8'd4);
    repeat (4090) @(negedge CLK);
    check("no_early_timeout", to_cnt, exp_to);
    repeat (10) @(negedge CLK);
    exp_to++;
    check_pulses("timeout");
    send_packet(4, 0, 100, 100, 3, 8'h66, 1'b0);
    wait_drain(50);
    check_pulses("after_timeout");

    // ID wrap 254 -> 0 is in sequence
    reset_dut();
    send_packet(253, 0, 3, 0, 1, 8'h01, 1'b0); wait_drain(50);
    send_packet(254, 1, 3, 1, 1, 8'h02, 1'b0); wait_drain(50);
    send_packet(0, 2, 3, 2, 1, 8'h03, 1'b0);   wait_drain(50);
    check_pulses("id_wrap");
    send_packet(2, 0, 3, 3, 2, 8'h04, 1'b0);   wait_drain(50);
    check_pulses("id_gap");

    // U clip at the channel edge
    send_packet(3, 1, 40, 318, 4, 8'h77, 1'b0);
    wait_drain(50);
    send_packet(4, 2, 41, 319, 3, 8'h78, 1'b0);
    wait_drain(50);

    // reset mid-run
    send_packet(5, 0, 42, 0, 100, 8'h99, 1'b0);
    repeat (10) @(negedge CLK);
    @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK);
    #1;
    check("midrun_reset_wr_en", {31'd0, o_wr_en}, 32'd0);
    check("midrun_reset_busy", {31'd0, o_busy}, 32'd0);
    exp_q.delete();
    m_armed = 1'b0;
    @(posedge CLK);
    #2 RST = 1'b1;

    // randomized packets
    id = $urandom_range(0, 254);
    for (int p = 0; p < 40; p++) begin
      ready_mode = 2;
      chan = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if ($urandom_range(0, 5) == 0) id = $urandom_range(0, 254);
      cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
      send_packet(id, chan, $urandom_range(0, 479), $urandom_range(0, 511), cnt,
                  $urandom_range(0, 255), 1'b0);
      if (chan != 3) id = (id + 1) % 255;
      wait_drain(400);
    end
    check_pulses("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
